mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller in the E stage of the P7 pipeline.
- Accepts MDU ops from E, models multiplier/divider latency with a down-counter, and commits results to HI/LO.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Exports busy_start for the hazard unit, which stalls D-stage MDU ops.
- Honours the exception/interrupt request so that an E-stage op that is flushed never changes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (minimum 1).
- DIV_CYCLES, 10, busy cycles for div/divu (minimum 1).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-low reset; state clears on a rising clk edge while reset==0.
- start  input  1  E-stage op valid this cycle.
- mdu_ctrl  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu; 11-15 reserved, treated as none.
- req  input  1  exception/interrupt flush; E-stage op is cancelled.
- srcA  input  32  rs operand (forwarded).
- srcB  input  32  rt operand (forwarded).
- busy  output  1  multi-cycle op in progress.
- busy_start  output  1  busy | (start & op is 1-4 or 9-10 & !req); combinational; drives the hazard unit.
- mdu_out  output  32  HI for mfhi, LO for mflo, else 0; combinational from current HI/LO.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State IDLE; counter=0.
  - busy=0, HI=0, LO=0, pending registers=0.
- States: IDLE and RUN.
- IDLE, start & !req & mult-class op (1-4, 9-10):
  - Compute the result from srcA/srcB into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (mult, multu, madd, maddu) or DIV_CYCLES (div, divu).
  - Enter RUN; busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - At the edge where counter==1: HI/LO <= pending values, go to IDLE, busy=0 in the following cycle.
  - Busy lasts exactly N cycles; HI/LO are visible to mfhi in the cycle busy deasserts.
- Arithmetic:
  - mult: signed 32x32 to 64 bits; multu: unsigned.
  - {HI,LO} = product.
  - div/divu: LO=quotient, HI=remainder; signed ops truncate toward zero and the remainder takes the dividend's sign.
  - Divide by zero: pending values equal the current HI/LO, so the architectural state is unchanged; busy timing is still DIV_CYCLES.
  - div 0x80000000 / -1: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE with start & !req: HI (or LO) <= srcA at that edge, no busy.
- mfhi/mflo: pure read; no state change.
- Any start while RUN: ignored; no latch, no HI/LO write. The hazard unit guarantees this does not happen; the block stays safe if it does.
- req with start in the same cycle: the op is cancelled entirely.
- req during RUN: no effect; the in-flight op was already past M and completes.
- Reserved codes (11-15) and code 0: no effect.
- Reset mid-RUN: abort immediately; busy=0, HI/LO=0 next cycle.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: codes 9 (madd, signed) and 10 (maddu, unsigned) accumulate.
  - pending {HI,LO} = {HI,LO} + product, 64-bit wrap-around.
  - Uses HI/LO sampled at start; latency MULT_CYCLES.
- Undefined: codes 9/10 are treated as none; they do not contribute to busy_start, and no accumulate logic is synthesised.

Test Plan:
- Reset then mult with srcA=0xFFFFFFFF (-1), srcB=2:
  - busy high for cycles 1-5.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi returns 0xFFFFFFFF.
- multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with srcA=-7 (0xFFFFFFF9), srcB=2:
  - busy for 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero:
  - Preload via mthi 0x1234, mtlo 0x5678, then divu srcB=0.
  - busy for 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- start+mult with req=1 in the same cycle: busy_start=0, busy stays 0, HI/LO unchanged. Separately, req asserted mid-RUN: the op still commits.
- Reset driven low at RUN cycle 3: next cycle busy=0, HI=LO=0. With MDU_MADD_EN, madd of 3*4 onto HI:LO=0:0xFFFFFFFF gives HI=1, LO=0x0000000B.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide controller for the E stage.
// Operations are accepted only in IDLE. The result is computed when the op
// is accepted and held in pending registers. A down-counter then models the
// unit latency before the result is committed to HI/LO.
// Optional feature macro: MDU_MADD_EN. When it is defined, codes 9/10
// (madd/maddu) accumulate the product into HI:LO. When it is not defined,
// those codes behave as "none".
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_ctrl,
    input  logic        req,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        busy_start,
    output logic [31:0] mdu_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_macc;
    logic               w_is_long;
    logic               w_signed;
    logic [63:0]        w_a_ext;
    logic [63:0]        w_b_ext;
    logic [63:0]        w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_den;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic [63:0]        w_pend;

    // Decode the op class and compute the candidate result from the operands.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_is_mul  = (mdu_ctrl == OP_MULT) || (mdu_ctrl == OP_MULTU);
        w_is_div  = (mdu_ctrl == OP_DIV)  || (mdu_ctrl == OP_DIVU);
`ifdef MDU_MADD_EN
        w_is_macc = (mdu_ctrl == OP_MADD) || (mdu_ctrl == OP_MADDU);
`else
        w_is_macc = 1'b0;
`endif
        w_is_long = w_is_mul || w_is_div || w_is_macc;
        w_signed  = (mdu_ctrl == OP_MULT) || (mdu_ctrl == OP_DIV) || (mdu_ctrl == OP_MADD);

        // A single 64x64 multiplier truncated to 64 bits gives both the
        // signed and the unsigned product, depending only on the extension.
        w_a_ext = {{32{w_signed & srcA[31]}}, srcA};
        w_b_ext = {{32{w_signed & srcB[31]}}, srcB};
        w_prod  = w_a_ext * w_b_ext;

        // Signed division runs on magnitudes. The quotient sign is a^b and
        // the remainder follows the dividend. 0x80000000 / -1 wraps to
        // 0x80000000 with remainder 0.
        w_a_neg = w_signed & srcA[31];
        w_b_neg = w_signed & srcB[31];
        w_a_mag = w_a_neg ? -srcA : srcA;
        w_b_mag = w_b_neg ? -srcB : srcB;
        w_den   = (srcB == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag = w_a_mag / w_den;
        w_r_mag = w_a_mag % w_den;
        w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
        w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

        w_pend = {r_hi, r_lo};
        if (w_is_mul) begin
            w_pend = w_prod;
        end else if (w_is_div) begin
            // Divide by zero leaves the architectural HI/LO unchanged.
            w_pend = (srcB == 32'd0) ? {r_hi, r_lo} : {w_rem, w_quot};
        end
`ifdef MDU_MADD_EN
        else if (w_is_macc) begin
            w_pend = {r_hi, r_lo} + w_prod;
        end
`endif
    end

    // Sequencer FSM: accept ops in IDLE, count down in RUN, commit on the last cycle.
    // NOTE: state registers use non-blocking assignments, so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !req) begin
                        if (w_is_long) begin
                            r_pend_hi <= w_pend[63:32];
                            r_pend_lo <= w_pend[31:0];
                            r_cnt     <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end else if (mdu_ctrl == OP_MTHI) begin
                            r_hi <= srcA;
                        end else if (mdu_ctrl == OP_MTLO) begin
                            r_lo <= srcA;
                        end
                    end
                end
                S_RUN: begin
                    // New starts and req are ignored here. The in-flight op always completes.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Hazard signal and the read port, both derived combinationally from the current state.
    always_comb begin
        busy_start = r_busy || (start && w_is_long && !req);
        mdu_out    = 32'd0;
        if (mdu_ctrl == OP_MFHI) begin
            mdu_out = r_hi;
        end else if (mdu_ctrl == OP_MFLO) begin
            mdu_out = r_lo;
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Testbench for mdu_sequencer. A directed table replays the documented
// cases, hand-written sequences cover the mid-RUN corner cases, and random
// ops are compared against an arithmetic reference model of HI/LO.
module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_ctrl;
    logic        req;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        busy_start;
    logic [31:0] mdu_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_ctrl(mdu_ctrl), .req(req),
        .srcA(srcA), .srcB(srcB), .busy(busy), .busy_start(busy_start),
        .mdu_out(mdu_out), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency of an accepted op. A value of zero means the op does not start the unit.
    function automatic int model_lat(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return MULT_N;
            4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
            4'd9, 4'd10: return MULT_N;
`endif
            default: return 0;
        endcase
    endfunction

    // New {HI,LO} after an accepted op, computed with plain language arithmetic.
    function automatic logic [63:0] model_apply(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [31:0] hi,
                                                input logic [31:0] lo);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        int          si = $signed(a);
        int          sj = $signed(b);
        int          q;
        int          r;
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return {hi, lo};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = si / sj;
                r = si % sj;
                return {32'(r), 32'(q)};
            end
            4'd4: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            4'd5: return {a, lo};
            4'd6: return {hi, a};
`ifdef MDU_MADD_EN
            4'd9:  return {hi, lo} + 64'(sa * sb);
            4'd10: return {hi, lo} + ua * ub;
`endif
            default: return {hi, lo};
        endcase
    endfunction

    // Issue one op and follow the busy window to completion. poke=1 raises req
    // mid-RUN. poke=2 presents an mthi start mid-RUN.
    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rq, input int poke,
                         input int exp_n, input logic [31:0] exp_out,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi = m_hi;
        logic [31:0] old_lo = m_lo;
        int          n = 0;
        bit          early = 0;
        @(negedge clk);
        start = 1'b1; mdu_ctrl = op; srcA = a; srcB = b; req = rq;
        #1;
        check({name, " busy_start"}, 64'(busy_start), 64'(exp_n > 0));
        check({name, " mdu_out"}, 64'(mdu_out), 64'(exp_out));
        @(posedge clk);
        #1;
        start = 1'b0; req = 1'b0; mdu_ctrl = 4'd0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (HI !== old_hi || LO !== old_lo) early = 1;
            if (poke == 1 && n == 2) req = 1'b1;
            if (poke == 2 && n == 2) begin
                start = 1'b1; mdu_ctrl = 4'd5; srcA = 32'hDEAD_BEEF;
                #1;
                check({name, " busy_start in RUN"}, 64'(busy_start), 64'd1);
            end
            if (n == 3) begin
                start = 1'b0; req = 1'b0; mdu_ctrl = 4'd0;
            end
        end
        check({name, " busy cycles"}, 64'(n), 64'(exp_n));
        check({name, " early commit"}, 64'(early), 64'd0);
        check({name, " HI/LO"}, {HI, LO}, {exp_hi, exp_lo});
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rq;
        int          exp_n;
        logic [31:0] exp_out;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{"mult -1*2",      4'd1,  32'hFFFF_FFFF, 32'd2, 1'b0, MULT_N, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{"mfhi",           4'd7,  32'd0, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{"multu",          4'd2,  32'hFFFF_FFFF, 32'd2, 1'b0, MULT_N, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[3]  = '{"div -7/2",       4'd3,  32'hFFFF_FFF9, 32'd2, 1'b0, DIV_N, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{"mthi",           4'd5,  32'h1234, 32'd0, 1'b0, 0, 32'd0, 32'h1234, 32'hFFFF_FFFD};
        vecs[5]  = '{"mtlo",           4'd6,  32'h5678, 32'd0, 1'b0, 0, 32'd0, 32'h1234, 32'h5678};
        vecs[6]  = '{"divu by zero",   4'd4,  32'd9, 32'd0, 1'b0, DIV_N, 32'd0, 32'h1234, 32'h5678};
        vecs[7]  = '{"mult with req",  4'd1,  32'd3, 32'd5, 1'b1, 0, 32'd0, 32'h1234, 32'h5678};
        vecs[8]  = '{"div overflow",   4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_N, 32'd0, 32'd0, 32'h8000_0000};
        vecs[9]  = '{"mflo",           4'd8,  32'd0, 32'd0, 1'b0, 0, 32'h8000_0000, 32'd0, 32'h8000_0000};
        vecs[10] = '{"reserved 12",    4'd12, 32'd1, 32'd1, 1'b0, 0, 32'd0, 32'd0, 32'h8000_0000};
        vecs[11] = '{"none",           4'd0,  32'd1, 32'd1, 1'b0, 0, 32'd0, 32'd0, 32'h8000_0000};
        vecs[12] = '{"mthi 0",         4'd5,  32'd0, 32'd0, 1'b0, 0, 32'd0, 32'd0, 32'h8000_0000};
        vecs[13] = '{"mtlo -1",        4'd6,  32'hFFFF_FFFF, 32'd0, 1'b0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF};
`ifdef MDU_MADD_EN
        vecs[14] = '{"madd 3*4",       4'd9,  32'd3, 32'd4, 1'b0, MULT_N, 32'd0, 32'h1, 32'hB};
        vecs[15] = '{"maddu big",      4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MULT_N, 32'd0, 32'hFFFF_FFFF, 32'h0000_000C};
`else
        vecs[14] = '{"madd disabled",  4'd9,  32'd3, 32'd4, 1'b0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        vecs[15] = '{"maddu disabled", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF};
`endif

        reset = 1'b0; start = 1'b0; mdu_ctrl = 4'd0; req = 1'b0; srcA = 32'd0; srcB = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset busy_start", 64'(busy_start), 64'd0);
        check("reset HI/LO", {HI, LO}, 64'd0);
        check("reset mdu_out", 64'(mdu_out), 64'd0);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rq, 0,
                  vecs[i].exp_n, vecs[i].exp_out, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // A req raised mid-RUN does not stop the commit.
        do_op("req mid-run", 4'd1, 32'd7, 32'd6, 1'b0, 1, MULT_N, 32'd0, 32'd0, 32'd42);
        // A start presented during RUN is ignored.
        do_op("start in run", 4'd2, 32'd10, 32'd10, 1'b0, 2, MULT_N, 32'd0, 32'd0, 32'd100);

        // Reset asserted in RUN cycle 3 aborts the op and clears HI/LO.
        do_op("preload mthi", 4'd5, 32'hAAAA, 32'd0, 1'b0, 0, 0, 32'd0, 32'hAAAA, 32'd100);
        @(negedge clk);
        start = 1'b1; mdu_ctrl = 4'd3; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; mdu_ctrl = 4'd0;
        repeat (3) @(negedge clk);
        check("busy before reset", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid-run reset busy", 64'(busy), 64'd0);
        check("mid-run reset HI/LO", {HI, LO}, 64'd0);
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;

        // Random ops compared against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        rq;
            logic [63:0] nxt;
            logic [31:0] out;
            int          lat;
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            rq  = ($urandom_range(0, 7) == 0);
            lat = rq ? 0 : model_lat(op);
            nxt = rq ? {m_hi, m_lo} : model_apply(op, a, b, m_hi, m_lo);
            out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
            do_op($sformatf("rand%0d op%0d", i, op), op, a, b, rq, 0, lat, out, nxt[63:32], nxt[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
